// File: rtl/mem_pkg.sv
// Shared constants and state encoding for the two-port RAM bus arbiter.
package mem_pkg;

   localparam logic [1:0] SIZE_NONE = 2'b00;
   localparam logic [1:0] SIZE_BYTE = 2'b01;
   localparam logic [1:0] SIZE_HALF = 2'b10;
   localparam logic [1:0] SIZE_WORD = 2'b11;

   localparam logic PORT_FETCH = 1'b0;
   localparam logic PORT_LSU   = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      RD1,
      RD2,
      WR,
      DONE
   } state_t;

endpackage

// File: rtl/mem_access_check.sv
// Rejects accesses that have no size, are misaligned for their size, or start outside the RAM window.
module mem_access_check #(
   parameter logic [31:0] RAM_START = 32'h0000_0000,
   parameter logic [31:0] RAM_SIZE  = 32'd256
) (
   input  logic [31:0] addr,
   input  logic [1:0]  size,
   output logic        err
);
   import mem_pkg::*;

   logic [32:0] addr_ext;
   logic [32:0] ram_lo;
   logic [32:0] ram_hi;
   logic        misaligned;
   logic        out_of_range;

   always_comb begin
      // 33-bit compare so a window ending at the top of the address space cannot wrap
      addr_ext     = {1'b0, addr};
      ram_lo       = {1'b0, RAM_START};
      ram_hi       = {1'b0, RAM_START} + {1'b0, RAM_SIZE};
      misaligned   = ((size == SIZE_HALF) && addr[0]) ||
                     ((size == SIZE_WORD) && (addr[1:0] != 2'b00));
      out_of_range = (addr_ext < ram_lo) || (addr_ext >= ram_hi);
      err          = (size == SIZE_NONE) || misaligned || out_of_range;
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin sequencer letting instruction fetch (port 0) and the load/store unit (port 1)
// share one RAM bus using a two-phase registered read or a single-phase write.
module mem_bus_arbiter
   import mem_pkg::*;
#(
   parameter logic [31:0] RAM_START = 32'h0000_0000,
   parameter logic [31:0] RAM_SIZE  = 32'd256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [1:0]  m0_size,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic        m0_ack,
   output logic        m0_err,
   output logic [31:0] m0_rdata,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [1:0]  m1_size,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic        m1_ack,
   output logic        m1_err,
   output logic [31:0] m1_rdata,
   output logic [31:0] bus_addr,
   inout  wire  [31:0] bus_data,
   output logic        bus_rw,
   output logic [1:0]  bus_size
);

   state_t      state, state_nxt;
   logic        last;
   logic        both_req, grant_vld, grant_port;
   logic        sel_we, sel_err;
   logic [1:0]  sel_size;
   logic [31:0] sel_addr, sel_wdata;
   logic        g_port;
   logic [1:0]  g_size;
   logic [31:0] g_addr, g_wdata;
   logic        cur_port;
   logic [1:0]  cur_size;
   logic [31:0] cur_addr, cur_wdata;
   logic        ack_set, err_set;
   logic        bus_oe;
   logic [31:0] bus_wdata;

   mem_access_check #(
      .RAM_START(RAM_START),
      .RAM_SIZE (RAM_SIZE)
   ) u_check (
      .addr(sel_addr),
      .size(sel_size),
      .err (sel_err)
   );

   always_comb begin
      both_req   = m0_req & m1_req;
      grant_vld  = m0_req | m1_req;
      grant_port = both_req ? ~last : m1_req;
      if (grant_port == PORT_LSU) begin
         sel_we    = m1_we;
         sel_size  = m1_size;
         sel_addr  = m1_addr;
         sel_wdata = m1_wdata;
      end else begin
         sel_we    = m0_we;
         sel_size  = m0_size;
         sel_addr  = m0_addr;
         sel_wdata = m0_wdata;
      end
   end

   // cur_* is the request the next bus cycle is built from: fresh grant in IDLE, latched copy after
   always_comb begin
      state_nxt = state;
      ack_set   = 1'b0;
      err_set   = 1'b0;
      cur_port  = g_port;
      cur_size  = g_size;
      cur_addr  = g_addr;
      cur_wdata = g_wdata;
      case (state)
         IDLE: begin
            if (grant_vld) begin
               cur_port  = grant_port;
               cur_size  = sel_size;
               cur_addr  = sel_addr;
               cur_wdata = sel_wdata;
               if (sel_err) begin
                  state_nxt = DONE;
                  ack_set   = 1'b1;
                  err_set   = 1'b1;
               end else begin
                  state_nxt = sel_we ? WR : RD1;
               end
            end
         end
         RD1:  state_nxt = RD2;
         RD2: begin
            state_nxt = DONE;
            ack_set   = 1'b1;
         end
         WR: begin
            state_nxt = DONE;
            ack_set   = 1'b1;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         last     <= 1'b1;
         m0_ack   <= 1'b0;
         m0_err   <= 1'b0;
         m1_ack   <= 1'b0;
         m1_err   <= 1'b0;
         m0_rdata <= 32'h0;
         m1_rdata <= 32'h0;
         bus_addr <= 32'h0;
         bus_rw   <= 1'b0;
         bus_size <= SIZE_NONE;
         bus_oe   <= 1'b0;
      end else begin
         state <= state_nxt;
         if ((state == IDLE) && both_req) begin
            last <= grant_port;
         end
         m0_ack <= ack_set && (cur_port == PORT_FETCH);
         m0_err <= err_set && (cur_port == PORT_FETCH);
         m1_ack <= ack_set && (cur_port == PORT_LSU);
         m1_err <= err_set && (cur_port == PORT_LSU);
         // RAM drives its registered read buffer during RD2
         if (state == RD2) begin
            if (cur_port == PORT_LSU) m1_rdata <= bus_data;
            else                      m0_rdata <= bus_data;
         end
         bus_rw <= (state_nxt == WR);
         bus_oe <= (state_nxt == WR);
         if (state_nxt inside {RD1, RD2, WR}) begin
            bus_size <= cur_size;
            bus_addr <= cur_addr;
         end else begin
            bus_size <= SIZE_NONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if ((state == IDLE) && grant_vld) begin
         g_port  <= grant_port;
         g_size  <= sel_size;
         g_addr  <= sel_addr;
         g_wdata <= sel_wdata;
      end
      bus_wdata <= cur_wdata;
   end

   assign bus_data = bus_oe ? bus_wdata : 'z;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: byte-addressed RAM model on the bus plus a shadow
// memory reference that predicts read data, error responses and latency from the access rules.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

   localparam logic [31:0] RAM_START = 32'h0000_0000;
   localparam logic [31:0] RAM_SIZE  = 32'd256;
   // bus is pulled up, so a released bus reads as all ones
   localparam logic [31:0] BUS_FLOAT = 32'hFFFF_FFFF;
   localparam logic [1:0]  SZ_NONE = 2'b00, SZ_BYTE = 2'b01, SZ_HALF = 2'b10, SZ_WORD = 2'b11;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        m0_req = 1'b0, m0_we = 1'b0;
   logic [1:0]  m0_size = 2'b00;
   logic [31:0] m0_addr = 32'h0, m0_wdata = 32'h0;
   logic        m0_ack, m0_err;
   logic [31:0] m0_rdata;
   logic        m1_req = 1'b0, m1_we = 1'b0;
   logic [1:0]  m1_size = 2'b00;
   logic [31:0] m1_addr = 32'h0, m1_wdata = 32'h0;
   logic        m1_ack, m1_err;
   logic [31:0] m1_rdata;
   logic [31:0] bus_addr;
   wire  [31:0] bus_data;
   logic        bus_rw;
   logic [1:0]  bus_size;

   int checks = 0;
   int errors = 0;

   bit [7:0]    ram    [0:255];
   bit [7:0]    shadow [0:255];
   logic        ram_drive = 1'b0;
   logic [31:0] ram_buf = 32'h0;

   always #5 clk = ~clk;

   mem_bus_arbiter #(
      .RAM_START(RAM_START),
      .RAM_SIZE (RAM_SIZE)
   ) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
      .bus_addr(bus_addr), .bus_data(bus_data), .bus_rw(bus_rw), .bus_size(bus_size)
   );

   for (genvar i = 0; i < 32; i++) begin : g_pull
      pullup pu (bus_data[i]);
   end

   assign bus_data = ram_drive ? ram_buf : 'z;

   function automatic int nbytes(input logic [1:0] size);
      case (size)
         SZ_BYTE: return 1;
         SZ_HALF: return 2;
         SZ_WORD: return 4;
         default: return 0;
      endcase
   endfunction

   function automatic logic [31:0] ram_rd(input logic [7:0] a, input logic [1:0] size);
      logic [31:0] v = 32'h0;
      for (int k = 0; k < nbytes(size); k++) v[8*k +: 8] = ram[a + 8'(k)];
      return v;
   endfunction

   // RAM: commits at the WR edge, loads its buffer at the RD1 edge and drives it for one cycle
   always @(posedge clk) begin
      if (bus_size != SZ_NONE && bus_rw) begin
         for (int k = 0; k < nbytes(bus_size); k++)
            ram[8'(bus_addr - RAM_START) + 8'(k)] <= bus_data[8*k +: 8];
      end
      if (bus_size != SZ_NONE && !bus_rw && !ram_drive) begin
         ram_buf   <= ram_rd(8'(bus_addr - RAM_START), bus_size);
         ram_drive <= 1'b1;
      end else begin
         ram_drive <= 1'b0;
      end
   end

   function automatic logic model_err(input logic [31:0] addr, input logic [1:0] size);
      longint a = longint'(addr);
      int     n = nbytes(size);
      if (n == 0) return 1'b1;
      if (a % n != 0) return 1'b1;
      return (a < longint'(RAM_START)) || (a >= longint'(RAM_START) + longint'(RAM_SIZE));
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] addr, input logic [1:0] size);
      logic [31:0] v = 32'h0;
      for (int k = 0; k < nbytes(size); k++) v[8*k +: 8] = shadow[int'(addr - RAM_START) + k];
      return v;
   endfunction

   function automatic void model_write(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] d);
      for (int k = 0; k < nbytes(size); k++) shadow[int'(addr - RAM_START) + k] = d[8*k +: 8];
   endfunction

   task automatic drive_req(input int port, input logic req, input logic we, input logic [1:0] size,
                            input logic [31:0] addr, input logic [31:0] wdata);
      if (port == 0) begin
         m0_req = req; m0_we = we; m0_size = size; m0_addr = addr; m0_wdata = wdata;
      end else begin
         m1_req = req; m1_we = we; m1_size = size; m1_addr = addr; m1_wdata = wdata;
      end
   endtask

   // Runs one request from IDLE; lat counts clock edges from first sample to the ack cycle (-1 = none)
   task automatic access(input int port, input logic we, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, output int lat, output logic err, output logic [31:0] rd,
                         output logic other_ack, output logic bus_seen, output logic ack_after);
      drive_req(port, 1'b1, we, size, addr, wdata);
      lat = -1; err = 1'b0; rd = 32'h0; other_ack = 1'b0; bus_seen = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (bus_size != SZ_NONE) bus_seen = 1'b1;
         if ((port == 0) ? m1_ack : m0_ack) other_ack = 1'b1;
         if ((port == 0) ? m0_ack : m1_ack) begin
            lat = c;
            err = (port == 0) ? m0_err : m1_err;
            rd  = (port == 0) ? m0_rdata : m1_rdata;
            break;
         end
      end
      drive_req(port, 1'b0, 1'b0, SZ_NONE, 32'h0, 32'h0);
      @(negedge clk);
      ack_after = m0_ack | m1_ack;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({m0_ack, m0_err, m1_ack, m1_err, bus_rw, bus_size} !== 7'b0) begin
         errors++; $display("FAIL reset_ctrl: got %b expected 0", {m0_ack, m0_err, m1_ack, m1_err, bus_rw, bus_size});
      end
      checks++;
      if ({m0_rdata, m1_rdata} !== 64'h0) begin
         errors++; $display("FAIL reset_rdata: got %h %h expected 0", m0_rdata, m1_rdata);
      end
      checks++;
      if (bus_addr !== 32'h0) begin
         errors++; $display("FAIL reset_bus_addr: got %h expected 0", bus_addr);
      end
      checks++;
      if (bus_data !== BUS_FLOAT) begin
         errors++; $display("FAIL reset_bus_data: got %h expected released %h", bus_data, BUS_FLOAT);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({m0_ack, m1_ack, bus_size} !== 4'b0) begin
         errors++; $display("FAIL reset_idle: got %b expected 0", {m0_ack, m1_ack, bus_size});
      end
   endtask

   task automatic test_write_read();
      int lat; logic err, oth, seen, stuck; logic [31:0] rd;
      access(1, 1'b1, SZ_WORD, 32'h10, 32'h1122_3344, lat, err, rd, oth, seen, stuck);
      model_write(32'h10, SZ_WORD, 32'h1122_3344);
      checks++;
      if (lat !== 2 || err !== 1'b0 || oth !== 1'b0 || stuck !== 1'b0) begin
         errors++; $display("FAIL wr_word: got lat=%0d err=%b other=%b stuck=%b expected lat=2 err=0 other=0 stuck=0", lat, err, oth, stuck);
      end
      access(0, 1'b0, SZ_WORD, 32'h10, 32'h0, lat, err, rd, oth, seen, stuck);
      checks++;
      if (lat !== 3 || err !== 1'b0 || oth !== 1'b0 || stuck !== 1'b0) begin
         errors++; $display("FAIL rd_word_timing: got lat=%0d err=%b other=%b stuck=%b expected lat=3 err=0 other=0 stuck=0", lat, err, oth, stuck);
      end
      checks++;
      if (rd !== model_read(32'h10, SZ_WORD)) begin
         errors++; $display("FAIL rd_word_data: got %h expected %h", rd, model_read(32'h10, SZ_WORD));
      end
   endtask

   task automatic test_byte_lanes();
      int lat; logic err, oth, seen, stuck; logic [31:0] rd;
      logic [31:0] t_addr [3] = '{32'h10, 32'h12, 32'h11};
      logic [1:0]  t_size [3] = '{SZ_WORD, SZ_HALF, SZ_BYTE};
      logic [31:0] t_exp  [3] = '{32'hAB22_3344, 32'h0000_AB22, 32'h0000_0033};
      access(1, 1'b1, SZ_BYTE, 32'h13, 32'h0000_00AB, lat, err, rd, oth, seen, stuck);
      model_write(32'h13, SZ_BYTE, 32'h0000_00AB);
      checks++;
      if (lat !== 2 || err !== 1'b0) begin
         errors++; $display("FAIL wr_byte: got lat=%0d err=%b expected lat=2 err=0", lat, err);
      end
      for (int i = 0; i < 3; i++) begin
         access(i % 2, 1'b0, t_size[i], t_addr[i], 32'h0, lat, err, rd, oth, seen, stuck);
         checks++;
         if (lat !== 3 || err !== 1'b0 || rd !== t_exp[i]) begin
            errors++; $display("FAIL lane_read_%0d: got lat=%0d err=%b data=%h expected lat=3 err=0 data=%h", i, lat, err, rd, t_exp[i]);
         end
      end
   endtask

   task automatic test_round_robin();
      int ack_cyc[$]; int ack_port[$]; int both = 0;
      @(negedge clk);
      rst = 1'b1;
      drive_req(0, 1'b1, 1'b0, SZ_WORD, 32'h10, 32'h0);
      drive_req(1, 1'b1, 1'b0, SZ_WORD, 32'h14, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         if (m0_ack && m1_ack) both++;
         if (m0_ack) begin
            ack_cyc.push_back(c); ack_port.push_back(0);
            checks++;
            if (m0_rdata !== model_read(32'h10, SZ_WORD)) begin
               errors++; $display("FAIL rr_m0_data: got %h expected %h", m0_rdata, model_read(32'h10, SZ_WORD));
            end
         end
         if (m1_ack) begin
            ack_cyc.push_back(c); ack_port.push_back(1);
            checks++;
            if (m1_rdata !== model_read(32'h14, SZ_WORD)) begin
               errors++; $display("FAIL rr_m1_data: got %h expected %h", m1_rdata, model_read(32'h14, SZ_WORD));
            end
         end
      end
      drive_req(0, 1'b0, 1'b0, SZ_NONE, 32'h0, 32'h0);
      drive_req(1, 1'b0, 1'b0, SZ_NONE, 32'h0, 32'h0);
      repeat (4) @(negedge clk);
      checks++;
      if (both != 0 || ack_cyc.size() != 4) begin
         errors++; $display("FAIL rr_count: got %0d acks (%0d double) expected 4 (0 double)", ack_cyc.size(), both);
      end
      // reads take 3 edges plus the DONE->IDLE gap, alternating from port 0
      for (int i = 0; i < ack_cyc.size(); i++) begin
         checks++;
         if (ack_port[i] != i % 2 || ack_cyc[i] != 3 + 4 * i) begin
            errors++; $display("FAIL rr_order_%0d: got port %0d at cycle %0d expected port %0d at cycle %0d", i, ack_port[i], ack_cyc[i], i % 2, 3 + 4 * i);
         end
      end
   endtask

   task automatic test_errors();
      int lat; logic err, oth, seen, stuck; logic [31:0] rd;
      logic [31:0] e_addr [5] = '{32'h12, 32'h11, 32'h10, 32'h100, 32'hFFFF_FFFC};
      logic [1:0]  e_size [5] = '{SZ_WORD, SZ_HALF, SZ_NONE, SZ_WORD, SZ_WORD};
      for (int i = 0; i < 5; i++) begin
         access(i % 2, 1'b1, e_size[i], e_addr[i], 32'hDEAD_BEEF, lat, err, rd, oth, seen, stuck);
         checks++;
         if (lat !== 1 || err !== 1'b1 || seen !== 1'b0 || oth !== 1'b0) begin
            errors++; $display("FAIL err_case_%0d: got lat=%0d err=%b bus=%b other=%b expected lat=1 err=1 bus=0 other=0", i, lat, err, seen, oth);
         end
      end
      access(0, 1'b0, SZ_WORD, 32'h10, 32'h0, lat, err, rd, oth, seen, stuck);
      checks++;
      if (lat !== 3 || err !== 1'b0 || rd !== model_read(32'h10, SZ_WORD)) begin
         errors++; $display("FAIL err_ram_intact: got lat=%0d err=%b data=%h expected lat=3 err=0 data=%h", lat, err, rd, model_read(32'h10, SZ_WORD));
      end
      access(1, 1'b1, SZ_WORD, 32'hFC, 32'hCAFE_F00D, lat, err, rd, oth, seen, stuck);
      model_write(32'hFC, SZ_WORD, 32'hCAFE_F00D);
      access(0, 1'b0, SZ_BYTE, 32'hFF, 32'h0, lat, err, rd, oth, seen, stuck);
      checks++;
      if (lat !== 3 || err !== 1'b0 || rd !== model_read(32'hFF, SZ_BYTE)) begin
         errors++; $display("FAIL top_byte: got lat=%0d err=%b data=%h expected lat=3 err=0 data=%h", lat, err, rd, model_read(32'hFF, SZ_BYTE));
      end
   endtask

   task automatic test_reset_mid();
      int lat; logic err, oth, seen, stuck, late_ack; logic [31:0] rd;
      drive_req(0, 1'b1, 1'b0, SZ_WORD, 32'h10, 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({m0_ack, m1_ack, bus_rw, bus_size} !== 5'b0 || bus_data !== BUS_FLOAT || m0_rdata !== 32'h0) begin
         errors++; $display("FAIL rst_mid_state: got ack=%b rw=%b size=%b data=%h rdata=%h expected 0 0 00 %h 0", m0_ack, bus_rw, bus_size, bus_data, m0_rdata, BUS_FLOAT);
      end
      rst = 1'b0;
      drive_req(0, 1'b0, 1'b0, SZ_NONE, 32'h0, 32'h0);
      late_ack = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (m0_ack | m1_ack) late_ack = 1'b1;
      end
      checks++;
      if (late_ack !== 1'b0) begin
         errors++; $display("FAIL rst_mid_no_ack: got ack=%b expected 0", late_ack);
      end
      access(0, 1'b0, SZ_WORD, 32'h10, 32'h0, lat, err, rd, oth, seen, stuck);
      checks++;
      if (lat !== 3 || err !== 1'b0 || rd !== model_read(32'h10, SZ_WORD)) begin
         errors++; $display("FAIL rst_mid_recover: got lat=%0d err=%b data=%h expected lat=3 err=0 data=%h", lat, err, rd, model_read(32'h10, SZ_WORD));
      end
   endtask

   task automatic test_bus_hygiene();
      logic [31:0] wd = 32'h0F0E_0D0C;
      drive_req(1, 1'b1, 1'b1, SZ_WORD, 32'h20, wd);
      @(negedge clk);
      checks++;
      if ({bus_rw, bus_size, bus_addr, bus_data} !== {1'b1, SZ_WORD, 32'h20, wd}) begin
         errors++; $display("FAIL hyg_wr: got rw=%b size=%b addr=%h data=%h expected 1 11 00000020 %h", bus_rw, bus_size, bus_addr, bus_data, wd);
      end
      @(negedge clk);
      model_write(32'h20, SZ_WORD, wd);
      checks++;
      if ({m1_ack, bus_rw, bus_size, bus_data} !== {1'b1, 1'b0, SZ_NONE, BUS_FLOAT}) begin
         errors++; $display("FAIL hyg_wr_done: got ack=%b rw=%b size=%b data=%h expected 1 0 00 %h", m1_ack, bus_rw, bus_size, bus_data, BUS_FLOAT);
      end
      drive_req(1, 1'b0, 1'b0, SZ_NONE, 32'h0, 32'h0);
      @(negedge clk);
      checks++;
      if (bus_size !== SZ_NONE || bus_data !== BUS_FLOAT) begin
         errors++; $display("FAIL hyg_idle: got size=%b data=%h expected 00 %h", bus_size, bus_data, BUS_FLOAT);
      end
      drive_req(0, 1'b1, 1'b0, SZ_HALF, 32'h22, 32'h0);
      @(negedge clk);
      checks++;
      if ({bus_rw, bus_size, bus_addr, bus_data} !== {1'b0, SZ_HALF, 32'h22, BUS_FLOAT}) begin
         errors++; $display("FAIL hyg_rd1: got rw=%b size=%b addr=%h data=%h expected 0 10 00000022 %h", bus_rw, bus_size, bus_addr, bus_data, BUS_FLOAT);
      end
      @(negedge clk);
      checks++;
      if (bus_data !== model_read(32'h22, SZ_HALF) || bus_rw !== 1'b0) begin
         errors++; $display("FAIL hyg_rd2: got rw=%b data=%h expected 0 %h", bus_rw, bus_data, model_read(32'h22, SZ_HALF));
      end
      @(negedge clk);
      checks++;
      if ({m0_ack, bus_size, bus_data, m0_rdata} !== {1'b1, SZ_NONE, BUS_FLOAT, model_read(32'h22, SZ_HALF)}) begin
         errors++; $display("FAIL hyg_rd_done: got ack=%b size=%b data=%h rdata=%h expected 1 00 %h %h", m0_ack, bus_size, bus_data, m0_rdata, BUS_FLOAT, model_read(32'h22, SZ_HALF));
      end
      drive_req(0, 1'b0, 1'b0, SZ_NONE, 32'h0, 32'h0);
      @(negedge clk);
   endtask

   task automatic test_random();
      int lat, port, exp_lat; logic err, oth, seen, stuck, we, exp_e; logic [31:0] rd, addr, wd, exp_rd;
      logic [1:0] size;
      for (int n = 0; n < 40; n++) begin
         port = $urandom_range(0, 1);
         we   = 1'($urandom_range(0, 1));
         size = 2'($urandom_range(0, 3));
         wd   = $urandom;
         case ($urandom_range(0, 7))
            6:       addr = 32'($urandom_range(256, 300));
            7:       addr = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
            default: addr = 32'($urandom_range(0, 255));
         endcase
         exp_e   = model_err(addr, size);
         exp_lat = exp_e ? 1 : (we ? 2 : 3);
         exp_rd  = (!exp_e && !we) ? model_read(addr, size) : 32'h0;
         access(port, we, size, addr, wd, lat, err, rd, oth, seen, stuck);
         if (!exp_e && we) model_write(addr, size, wd);
         checks++;
         if (lat !== exp_lat || err !== exp_e || oth !== 1'b0 || stuck !== 1'b0) begin
            errors++; $display("FAIL rand_%0d_resp: p%0d we=%b sz=%b a=%h got lat=%0d err=%b other=%b stuck=%b expected lat=%0d err=%b other=0 stuck=0", n, port, we, size, addr, lat, err, oth, stuck, exp_lat, exp_e);
         end
         if (!exp_e && !we) begin
            checks++;
            if (rd !== exp_rd) begin
               errors++; $display("FAIL rand_%0d_data: p%0d sz=%b a=%h got %h expected %h", n, port, size, addr, rd, exp_rd);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_byte_lanes();
      test_round_robin();
      test_errors();
      test_reset_mid();
      test_bus_hygiene();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
